// File: rtl/cam_pattern_tx.sv
// cam_pattern_tx: parallel camera-sensor emulator.
// Generates FVAL/LVAL framed 12-bit test patterns with programmable geometry
// and blanking. Every output is a register loaded from the next-state
// decode, so the pixel data always lines up with cam_lval.
module cam_pattern_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int FV_TO_LV = 4,
  parameter int LV_TO_FV = 4,
  parameter int V_BLANK  = 45
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [11:0] cam_d,
  output logic        cam_fval,
  output logic        cam_lval,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FV_LEAD  = 3'd1,
    LINE     = 3'd2,
    HBLANK   = 3'd3,
    FV_TRAIL = 3'd4,
    VBLANK   = 3'd5
  } state_t;

  // Terminal values of the per-state counters.
  localparam logic [11:0] X_LAST    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST    = 12'(V_ACTIVE - 1);
  localparam logic [15:0] LEAD_LAST = 16'(FV_TO_LV - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] TR_LAST   = 16'(LV_TO_FV - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [11:0] x_reg, x_next;
  logic [11:0] y_reg, y_next;
  logic [1:0]  pat_reg, pat_next;      // pattern latched at frame start
  logic [11:0] base_reg, base_next;    // frame number latched at frame start
  logic [15:0] fc_next;
  logic [11:0] d_next;
  logic        fval_next, lval_next, busy_next;

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      pat_reg     <= '0;
      base_reg    <= '0;
      frame_count <= '0;
      cam_d       <= '0;
      cam_fval    <= 1'b0;
      cam_lval    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      pat_reg     <= pat_next;
      base_reg    <= base_next;
      frame_count <= fc_next;
      cam_d       <= d_next;
      cam_fval    <= fval_next;
      cam_lval    <= lval_next;
      busy        <= busy_next;
    end
  end

  // Next-state and counter decode; enable is only looked at in IDLE and at
  // the end of VBLANK, so a running frame always completes.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    pat_next   = pat_reg;
    base_next  = base_reg;
    fc_next    = frame_count;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = FV_LEAD;
          cnt_next   = '0;
          x_next     = '0;
          y_next     = '0;
          pat_next   = pattern_sel;
          base_next  = frame_count[11:0];
        end
      end
      FV_LEAD: begin
        if (cnt_reg == LEAD_LAST) begin
          state_next = LINE;
          x_next     = '0;
          y_next     = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      LINE: begin
        if (x_reg == X_LAST) begin
          cnt_next   = '0;
          state_next = (y_reg < Y_LAST) ? HBLANK : FV_TRAIL;
        end else begin
          x_next = x_reg + 12'd1;
        end
      end
      HBLANK: begin
        if (cnt_reg == HB_LAST) begin
          state_next = LINE;
          x_next     = '0;
          y_next     = y_reg + 12'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      FV_TRAIL: begin
        if (cnt_reg == TR_LAST) begin
          state_next = VBLANK;
          cnt_next   = '0;
          fc_next    = frame_count + 16'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      VBLANK: begin
        if (cnt_reg == VB_LAST) begin
          cnt_next = '0;
          if (enable) begin
            state_next = FV_LEAD;
            x_next     = '0;
            y_next     = '0;
            pat_next   = pattern_sel;
            base_next  = frame_count[11:0];
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs match the state.
  always_comb begin
    fval_next = (state_next == FV_LEAD) || (state_next == LINE) ||
                (state_next == HBLANK)  || (state_next == FV_TRAIL);
    lval_next = (state_next == LINE);
    busy_next = (state_next != IDLE);
    d_next    = '0;
    if (lval_next) begin
      case (pat_next)
        2'd0:    d_next = x_next;
        2'd1:    d_next = y_next;
        2'd2:    d_next = (x_next[3] ^ y_next[3]) ? 12'hFFF : 12'h000;
        default: d_next = base_next;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Testbench for cam_pattern_tx with a small 8x4 frame geometry.
module tb_cam_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] cam_d;
  logic        cam_fval;
  logic        cam_lval;
  logic        busy;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  cam_pattern_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(3),
    .FV_TO_LV(2), .LV_TO_FV(2), .V_BLANK(5)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .enable       (enable),
    .pattern_sel  (pattern_sel),
    .cam_d        (cam_d),
    .cam_fval     (cam_fval),
    .cam_lval     (cam_lval),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // One frame record: selected pattern, hand-computed pixel rule, final count.
  typedef struct {
    logic [1:0]  sel;
    logic [11:0] base;    // constant part of every pixel
    bit          ramp_x;  // pixel adds column index
    bit          ramp_y;  // pixel adds line index
    logic [15:0] fc_after;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame timing: 2 lead + 4 lines of 8 with 3-cycle gaps + 2 trail = 45 high,
  // then 5 low. Sample index i counts negedges from the first fval-high one.
  task automatic run_frame(input vec_t v, input logic [1:0] next_sel,
                           input bit drop_en, input int exp_wait);
    int waited = 0;
    int p, line, col;
    bit exp_l;
    int exp_d;
    do begin
      @(negedge clk);
      waited++;
    end while (!cam_fval && waited < 200);
    check("fval_rise_wait", waited, exp_wait);
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clk);
      p     = i - 2;
      line  = (p >= 0) ? p / 11 : 0;
      col   = (p >= 0) ? p % 11 : 0;
      exp_l = (p >= 0) && (p < 43) && (col < 8);
      exp_d = exp_l ? (int'(v.base) + (v.ramp_x ? col : 0) + (v.ramp_y ? line : 0)) : 0;
      check("fval", int'(cam_fval), (i < 45) ? 1 : 0);
      check("lval", int'(cam_lval), exp_l ? 1 : 0);
      check("cam_d", int'(cam_d), exp_d);
      check("busy", int'(busy), 1);
      if (i == 44) check("frame_count_before_fall", int'(frame_count), int'(v.fc_after) - 1);
      if (i == 45) check("frame_count_after_fall", int'(frame_count), int'(v.fc_after));
      if (i == 10) begin
        pattern_sel = next_sel;
        if (drop_en) enable = 1'b0;
      end
    end
    $display("frame sel=%0d done, frame_count=%0d", v.sel, frame_count);
  endtask

  initial begin
    int waited;
    vecs[0] = '{sel: 2'd0, base: 12'd0, ramp_x: 1, ramp_y: 0, fc_after: 16'd1};
    vecs[1] = '{sel: 2'd1, base: 12'd0, ramp_x: 0, ramp_y: 1, fc_after: 16'd2};
    vecs[2] = '{sel: 2'd2, base: 12'd0, ramp_x: 0, ramp_y: 0, fc_after: 16'd3};
    vecs[3] = '{sel: 2'd3, base: 12'd3, ramp_x: 0, ramp_y: 0, fc_after: 16'd4};
    vecs[4] = '{sel: 2'd3, base: 12'd4, ramp_x: 0, ramp_y: 0, fc_after: 16'd5};
    vecs[5] = '{sel: 2'd3, base: 12'd5, ramp_x: 0, ramp_y: 0, fc_after: 16'd6};

    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: everything low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_fval", int'(cam_fval), 0);
      check("idle_lval", int'(cam_lval), 0);
      check("idle_d", int'(cam_d), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_fc", int'(frame_count), 0);
    end
    $display("idle after reset checked");

    // Back-to-back frames; pattern_sel for the next frame changes mid-frame,
    // enable drops mid-way through the last one.
    pattern_sel = vecs[0].sel;
    enable = 1'b1;
    for (int f = 0; f < 6; f++)
      run_frame(vecs[f], (f < 5) ? vecs[f + 1].sel : 2'd0, f == 5, 1);

    // After the dropped-enable frame: back in IDLE.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_fval", int'(cam_fval), 0);
      check("post_busy", int'(busy), 0);
      check("post_fc", int'(frame_count), 6);
    end
    $display("idle after enable drop checked");

    // Reset mid-line.
    enable = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!cam_fval && waited < 200);
    check("rst_seq_wait", waited, 1);
    repeat (5) @(negedge clk);
    check("pre_rst_lval", int'(cam_lval), 1);
    check("pre_rst_d", int'(cam_d), 3);
    rst_n = 1'b0;
    #1;
    check("rst_fval", int'(cam_fval), 0);
    check("rst_lval", int'(cam_lval), 0);
    check("rst_d", int'(cam_d), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fc", int'(frame_count), 0);
    $display("async reset mid-line checked");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(vecs[0], 2'd0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
